// File: rtl/uart_tx_dev.sv
// ---------------------------------------------------------------------------
// uart_tx_dev: memory-mapped UART transmitter (8N1, optional even parity).
//
// CPU writes to DATA queue bytes in a FIFO_DEPTH-entry FIFO. While CTRL.TXEN
// is set, the transmitter pops one byte at a time and sends it on txd as
// start bit, eight data bits LSB first, optional parity bit, then stop bit.
// Each bit lasts max(DIVISOR,1) clocks. DONE is set when a frame ends with
// nothing left to send. IRQ is the registered AND of DONE and CTRL.IE.
//
// Register map (Addr[3:2]):
//   0 DATA     W: push Din[7:0]          R: 0
//   1 CTRL     bit0 TXEN, bit1 IE, bit2 PAR (parity builds only)
//   2 STATUS   bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 OVF, bit4 DONE,
//              [8 +: log2(FIFO_DEPTH)+1] FIFO count; any write clears OVF/DONE
//   3 DIVISOR  [15:0] bit period in clocks
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   Addr   word address [31:2]; only [3:2] decoded (bridge does base decode)
//   WE     write strobe, sampled on rising clk
//   Din    write data
//   Dout   read data, combinational from Addr
//   IRQ    registered level interrupt
//   txd    serial output, idle high
//
// Build option: define UART_TX_PARITY_EN to make CTRL.PAR writable and add
// the even-parity bit state. Without it, frames are always 8N1.
// ---------------------------------------------------------------------------
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;

    // Bus handshake: a register write happens on every rising clk edge where
    // WE is high; reads are purely combinational with no wait states.
    logic wr_data, wr_ctrl, wr_stat, wr_div;
    assign wr_data = WE && (Addr[3:2] == 2'd0);
    assign wr_ctrl = WE && (Addr[3:2] == 2'd1);
    assign wr_stat = WE && (Addr[3:2] == 2'd2);
    assign wr_div  = WE && (Addr[3:2] == 2'd3);

    logic unused_ok;
    assign unused_ok = ^{Addr[31:4], Din[31:16]};

    // ---------------- registers ----------------
    logic        txen, ie, ovf, done;
    logic [15:0] divisor;
`ifdef UART_TX_PARITY_EN
    logic        par_en;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty, push, pop;

    // ---------------- transmitter ----------------
    logic [2:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif
    logic [15:0] div_eff;
    logic        bit_end, set_done;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = wr_data && !fifo_full;
    assign pop        = (state == S_IDLE) && txen && !fifo_empty;
    assign div_eff    = (divisor == 16'd0) ? 16'd1 : divisor;
    assign bit_end    = (bit_cnt == 16'd1);
    // A push in the exit cycle means more work is coming, so no DONE.
    assign set_done   = (state == S_STOP) && bit_end && fifo_empty && !wr_data;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Din[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txen    <= 1'b0;
            ie      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en  <= 1'b0;
`endif
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
            done    <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                txen   <= Din[0];
                ie     <= Din[1];
`ifdef UART_TX_PARITY_EN
                par_en <= Din[2];
`endif
            end
            if (wr_div) divisor <= Din[15:0];
            if (wr_data && fifo_full) ovf <= 1'b1;
            else if (wr_stat)         ovf <= 1'b0;
            if (set_done)                 done <= 1'b1;
            else if (wr_stat || wr_data)  done <= 1'b0;
            IRQ <= done & ie;
        end
    end

    // Bit timing: bit_cnt holds the clocks left in the current bit. It is
    // reloaded from DIVISOR only at a bit boundary, so a mid-frame DIVISOR
    // write never stretches or shortens the bit already in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_cnt <= 16'd1;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state != S_IDLE) begin
                if (bit_end) bit_cnt <= div_eff;
                else         bit_cnt <= bit_cnt - 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^mem[rd_ptr];
`endif
                        bit_cnt <= div_eff;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= par_en ? S_PAR : S_STOP;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PAR: begin
                    if (bit_end) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (bit_end) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        txd = 1'b1;
        case (state)
            S_START: txd = 1'b0;
            S_DATA:  txd = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd1: begin
                Dout[0] = txen;
                Dout[1] = ie;
`ifdef UART_TX_PARITY_EN
                Dout[2] = par_en;
`endif
            end
            2'd2: begin
                Dout[0]         = (state != S_IDLE);
                Dout[1]         = fifo_full;
                Dout[2]         = fifo_empty;
                Dout[3]         = ovf;
                Dout[4]         = done;
                Dout[8 +: AW+1] = count;
            end
            2'd3:    Dout[15:0] = divisor;
            default: Dout = '0;
        endcase
    end

endmodule
